// File: rtl/piezo_pkg.sv
// Shared types and helpers for the piezo melody player.
// Holds the sequencer state encoding and a width helper that never returns zero.
package piezo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        GAP,
        NEXT,
        DONE
    } state_t;

    // Like $clog2, but a single-entry range still gets a 1-bit index
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles its output every hp enabled cycles.
// Dropping en clears the counter and silences the output on the next edge.
module piezo_tone_gen #(
    parameter int HP_W = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [HP_W-1:0] hp,
    output logic            piezo
);

    logic [HP_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            piezo <= 1'b0;
        end else if (!en) begin
            count <= '0;
            piezo <= 1'b0;
        end else if (count == hp - HP_W'(1)) begin
            count <= '0;
            piezo <= ~piezo;
        end else begin
            count <= count + HP_W'(1);
        end
    end

endmodule

// File: rtl/piezo_melody_player.sv
// Multi-channel piezo sequencer: per-channel tone tables, lowest-index arbitration, note/gap timing.
// Define PIEZO_PREEMPT_EN to let a lower-index request abort a sequence that is already playing.
module piezo_melody_player
    import piezo_pkg::*;
#(
    parameter int N_EVT       = 2,
    parameter int N_NOTES     = 4,
    parameter int HP_W        = 14,
    parameter int NOTE_CYCLES = 25000,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_EVT-1:0]              evt_req,
    input  logic                          cfg_we,
    input  logic [clog2_min1(N_EVT)-1:0]   cfg_evt,
    input  logic [clog2_min1(N_NOTES)-1:0] cfg_idx,
    input  logic [HP_W-1:0]               cfg_hp,
    output logic                          busy,
    output logic [clog2_min1(N_EVT)-1:0]   cur_evt,
    output logic                          done,
    output logic                          piezo
);

    localparam int EVT_W   = clog2_min1(N_EVT);
    localparam int IDX_W   = clog2_min1(N_NOTES);
    localparam int TMR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = clog2_min1(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] NOTE_LAST = TMR_W'(NOTE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [HP_W-1:0]  tone_table [N_EVT][N_NOTES];
    state_t           state;
    logic [IDX_W-1:0] note_idx;
    logic [TMR_W-1:0] timer;
    logic [HP_W-1:0]  cur_hp;

    logic             req_any;
    logic [EVT_W-1:0] req_win;
    logic [HP_W-1:0]  win_hp0;
    logic             last_slot;
    logic [IDX_W-1:0] next_idx;
    logic [HP_W-1:0]  next_hp;
    logic             preempt;
    logic             start;
    logic             tone_en;

    // Lowest set request bit wins; the others are simply dropped
    always_comb begin
        req_any = 1'b0;
        req_win = '0;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (evt_req[i]) begin
                req_any = 1'b1;
                req_win = EVT_W'(i);
            end
        end
    end

    assign win_hp0   = tone_table[req_win][0];
    assign last_slot = (int'(note_idx) == N_NOTES - 1);
    assign next_idx  = last_slot ? '0 : note_idx + IDX_W'(1);
    assign next_hp   = tone_table[cur_evt][next_idx];

`ifdef PIEZO_PREEMPT_EN
    assign preempt = req_any && (req_win < cur_evt) &&
                     (state == PLAY || state == GAP || state == NEXT);
`else
    assign preempt = 1'b0;
`endif

    assign start = preempt || (state == IDLE && req_any);

    // The tone is cut during the final note cycle so the output is already low when the note ends
    assign tone_en = (state == PLAY) && (timer != NOTE_LAST) && !preempt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < N_EVT; e++) begin
                for (int n = 0; n < N_NOTES; n++) begin
                    tone_table[e][n] <= '0;
                end
            end
        end else if (cfg_we && int'(cfg_evt) < N_EVT && int'(cfg_idx) < N_NOTES) begin
            tone_table[cfg_evt][cfg_idx] <= cfg_hp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_evt  <= '0;
            note_idx <= '0;
            timer    <= '0;
            cur_hp   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cur_evt  <= req_win;
                note_idx <= '0;
                timer    <= '0;
                cur_hp   <= win_hp0;
                busy     <= 1'b1;
                if (win_hp0 == '0) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    state <= PLAY;
                end
            end else begin
                case (state)
                    IDLE: ;
                    PLAY: begin
                        if (timer == NOTE_LAST) begin
                            timer <= '0;
                            state <= (GAP_CYCLES == 0) ? NEXT : GAP;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    GAP: begin
                        if (timer == GAP_LAST) begin
                            timer <= '0;
                            state <= NEXT;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    NEXT: begin
                        if (last_slot || next_hp == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            note_idx <= next_idx;
                            cur_hp   <= next_hp;
                            state    <= PLAY;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    piezo_tone_gen #(
        .HP_W (HP_W)
    ) u_tone (
        .clk   (clk),
        .rst   (rst),
        .en    (tone_en),
        .hp    (cur_hp),
        .piezo (piezo)
    );

endmodule

// File: tb/tb_piezo_melody_player.sv
// Scoreboard bench for piezo_melody_player: a cycle-level model of each sequence is queued at request
// time and compared against the outputs captured every cycle. Preemption expectations follow PIEZO_PREEMPT_EN.
module tb_piezo_melody_player;

    localparam int NOTE = 40;
    localparam int GAP  = 8;

    typedef struct packed {
        logic p;
        logic b;
        logic d;
        logic e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] evt_req;
    logic       cfg_we;
    logic [0:0] cfg_evt;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_hp;
    logic       busy;
    logic [0:0] cur_evt;
    logic       done;
    logic       piezo;

    exp_t exp_q[$];
    exp_t got_q[$];
    int   shadow [2][4];
    int   pass_count  = 0;
    int   check_count = 0;
    int   fail_count  = 0;

    always #5 clk = ~clk;

    piezo_melody_player #(
        .N_EVT       (2),
        .N_NOTES     (4),
        .HP_W        (8),
        .NOTE_CYCLES (NOTE),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .evt_req (evt_req),
        .cfg_we  (cfg_we),
        .cfg_evt (cfg_evt),
        .cfg_idx (cfg_idx),
        .cfg_hp  (cfg_hp),
        .busy    (busy),
        .cur_evt (cur_evt),
        .done    (done),
        .piezo   (piezo)
    );

    function automatic exp_t mk(input logic p, input logic b, input logic d, input logic e);
        return {p, b, d, e};
    endfunction

    // Expected per-cycle outputs from the first cycle after the request is sampled
    task automatic push_seq(input int ch, input int idle_after);
        int   s;
        int   hp;
        logic c;
        c = 1'(ch);
        if (shadow[ch][0] == 0) begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, c));
        end else begin
            s = 0;
            forever begin
                hp = shadow[ch][s];
                for (int k = 0; k < NOTE; k++) exp_q.push_back(mk(1'((k / hp) % 2), 1'b1, 1'b0, c));
                for (int g = 0; g < GAP + 1; g++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, c));
                if (s == 3 || shadow[ch][s + 1] == 0) begin
                    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, c));
                    break;
                end
                s++;
            end
        end
        for (int i = 0; i < idle_after; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, c));
    endtask

    task automatic write_slot(input int ch, input int idx, input int hp);
        cfg_we  = 1'b1;
        cfg_evt = 1'(ch);
        cfg_idx = 2'(idx);
        cfg_hp  = 8'(hp);
        @(negedge clk);
        cfg_we = 1'b0;
        shadow[ch][idx] = hp;
    endtask

    task automatic request(input logic [1:0] val);
        evt_req = val;
        @(negedge clk);
    endtask

    // Captures one output sample per expected entry while applying timed stimulus
    task automatic play(input int release_at, input int pulse_at, input logic [1:0] pulse_val,
                        input int wr_at, input int wr_idx, input int wr_hp, input int stop_at);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n && i != stop_at; i++) begin
            got_q.push_back({piezo, busy, done, cur_evt});
            if (i == release_at) evt_req = 2'b00;
            if (pulse_at >= 0 && i == pulse_at) evt_req = pulse_val;
            if (pulse_at >= 0 && i == pulse_at + 1) evt_req = 2'b00;
            if (wr_at >= 0 && i == wr_at) begin
                cfg_we  = 1'b1;
                cfg_evt = 1'b1;
                cfg_idx = 2'(wr_idx);
                cfg_hp  = 8'(wr_hp);
            end
            if (wr_at >= 0 && i == wr_at + 1) cfg_we = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        evt_req = 2'b00;
        cfg_we  = 1'b0;
        cfg_evt = 1'b0;
        cfg_idx = 2'b00;
        cfg_hp  = 8'd0;
        for (int e = 0; e < 2; e++) for (int n = 0; n < 4; n++) shadow[e][n] = 0;
        repeat (3) @(negedge clk);
        check_count++;
        if (piezo !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_piezo got %b want 0", piezo); end
        else pass_count++;
        check_count++;
        if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        else pass_count++;
        check_count++;
        if (done !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_done got %b want 0", done); end
        else pass_count++;
        check_count++;
        if (cur_evt !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_cur_evt got %b want 0", cur_evt); end
        else pass_count++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_melody;
        exp_t want, got;
        int   n;
        write_slot(0, 0, 5);
        write_slot(0, 1, 10);
        push_seq(0, 3);
        request(2'b01);
        play(0, -1, 2'b00, -1, 0, 0, -1);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL basic cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
    endtask

    task automatic test_simultaneous;
        exp_t want, got;
        int   n;
        push_seq(0, 6);
        request(2'b11);
        play(0, -1, 2'b00, -1, 0, 0, -1);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL simultaneous cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
    endtask

    task automatic test_empty_channel;
        exp_t want, got;
        int   n;
        push_seq(1, 3);
        request(2'b10);
        play(0, -1, 2'b00, -1, 0, 0, -1);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL empty_channel cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
    endtask

    task automatic test_full_table;
        exp_t want, got;
        int   n;
        write_slot(1, 0, 3);
        write_slot(1, 1, 4);
        write_slot(1, 2, 9);
        write_slot(1, 3, 6);
        shadow[1][2] = 5;
        push_seq(1, 3);
        request(2'b10);
        play(0, -1, 2'b00, 10, 2, 5, -1);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL full_table cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
    endtask

    task automatic test_preempt;
        exp_t want, got;
        int   n;
        push_seq(1, 3);
`ifdef PIEZO_PREEMPT_EN
        while (exp_q.size() > 21) void'(exp_q.pop_back());
        push_seq(0, 3);
`endif
        request(2'b10);
        play(0, 20, 2'b01, -1, 0, 0, -1);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL preempt cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
    endtask

    task automatic test_back_to_back;
        exp_t want, got;
        int   n;
        int   first_len;
        push_seq(0, 1);
        first_len = exp_q.size();
        push_seq(0, 3);
        request(2'b01);
        play(first_len, -1, 2'b00, -1, 0, 0, -1);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL back_to_back cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
    endtask

    task automatic test_reset_mid_play;
        exp_t want, got;
        int   n;
        push_seq(0, 0);
        request(2'b01);
        play(0, -1, 2'b00, -1, 0, 0, 8);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL pre_reset cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
        want = exp_q.pop_front();
        check_count++;
        if (piezo !== want.p) begin
            fail_count++;
            $display("[TB] FAIL mid_play_piezo got %b want %b", piezo, want.p);
        end else pass_count++;
        #2 rst = 1'b1;
        #1;
        check_count++;
        if (piezo !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_piezo got %b want 0", piezo); end
        else pass_count++;
        check_count++;
        if (busy !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        else pass_count++;
        exp_q.delete();
        for (int e = 0; e < 2; e++) for (int k = 0; k < 4; k++) shadow[e][k] = 0;
        @(negedge clk);
        rst = 1'b0;
        push_seq(0, 2);
        request(2'b01);
        play(0, -1, 2'b00, -1, 0, 0, -1);
        n = 0;
        while (got_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = got_q.pop_front();
            check_count++;
            if (got !== want) begin
                fail_count++;
                $display("[TB] FAIL post_reset cycle %0d got pbde=%b want pbde=%b", n, got, want);
            end else pass_count++;
            n++;
        end
    endtask

    initial begin
        $display("[TB] piezo_melody_player bench start");
        test_reset;
        test_basic_melody;
        test_simultaneous;
        test_empty_channel;
        test_full_table;
        test_preempt;
        test_back_to_back;
        test_reset_mid_play;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
